// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the phase-state encoding used by the timing
// generator and the display stage.
package vga_timing_pkg;

  // 640x480@60 defaults
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int unsigned RGB_W   = 3;
  localparam int unsigned PIXEL_W = 20;

  // Phase of one scan axis; the same encoding serves horizontal and vertical
  typedef enum logic [1:0] {
    PH_ACT   = 2'd0,
    PH_FRONT = 2'd1,
    PH_SYNC  = 2'd2,
    PH_BACK  = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter plus the active/front/sync/back phase FSM.
// The counter and phase advance only when en_i is high.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter  int unsigned FP     = DEF_H_FP,
  parameter  int unsigned SYNC   = DEF_H_SYNC,
  parameter  int unsigned BP     = DEF_H_BP,
  localparam int unsigned TOTAL  = ACTIVE + FP + SYNC + BP,
  localparam int unsigned CNT_W  = $clog2(TOTAL)
) (
  input  logic             rst,
  input  logic             vga_clk,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output phase_e           phase_o,
  output logic             wrap_c_o
);

  localparam logic [CNT_W-1:0] LAST_ACT   = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC  = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST_TOTAL = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  phase_e           phase_q;

  // Wrap at the last position of the axis; the next axis uses it as enable
  always_comb begin
    wrap_c_o = en_i && (cnt_q == LAST_TOTAL);
    cnt_d    = wrap_c_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter and phase FSM; the phase always matches the current count
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= PH_ACT;
    end else if (en_i) begin
      cnt_q <= cnt_d;
      case (phase_q)
        PH_ACT:   if (cnt_q == LAST_ACT)   phase_q <= PH_FRONT;
        PH_FRONT: if (cnt_q == LAST_FRONT) phase_q <= PH_SYNC;
        PH_SYNC:  if (cnt_q == LAST_SYNC)  phase_q <= PH_BACK;
        PH_BACK:  if (cnt_q == LAST_TOTAL) phase_q <= PH_ACT;
        default:                           phase_q <= PH_ACT;
      endcase
    end
  end

  assign cnt_o   = cnt_q;
  assign phase_o = phase_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: scan counters, registered position strobes, and a
// sync/colour output pipeline that keeps the DAC pins and sync pulses aligned.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic               rst,
  input  logic               vga_clk,
  input  logic [RGB_W-1:0]   color_in,
  output logic               visible,
  output logic               line,
  output logic               frame,
  output logic [PIXEL_W-1:0] pixel,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic [RGB_W-1:0]   vga_rgb
);

  localparam int unsigned LINE_LEN    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned FRAME_LINES = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HCNT_W      = $clog2(LINE_LEN);
  localparam int unsigned VCNT_W      = $clog2(FRAME_LINES);

  logic [HCNT_W-1:0] h_cnt;
  logic [VCNT_W-1:0] v_cnt;
  phase_e            h_phase;
  phase_e            v_phase;
  logic              h_wrap;
  logic              v_wrap_unused;

  // Horizontal axis runs every pixel clock
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .rst      (rst),
    .vga_clk  (vga_clk),
    .en_i     (1'b1),
    .cnt_o    (h_cnt),
    .phase_o  (h_phase),
    .wrap_c_o (h_wrap)
  );

  // Vertical axis steps once per line
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .rst      (rst),
    .vga_clk  (vga_clk),
    .en_i     (h_wrap),
    .cnt_o    (v_cnt),
    .phase_o  (v_phase),
    .wrap_c_o (v_wrap_unused)
  );

  logic               vis_c;
  logic               line_c;
  logic               frame_c;
  logic               first_c;
  logic [PIXEL_W-1:0] pixel_d;

  logic               visible_q;
  logic               line_q;
  logic               frame_q;
  logic [PIXEL_W-1:0] pixel_q;
  logic               hs_n1_q, hs_n2_q, hsync_n_q;
  logic               vs_n1_q, vs_n2_q, vsync_n_q;
  logic               vis_dly_q;
  logic [RGB_W-1:0]   rgb_q;

  // Position decode; the top-left pixel keeps index 0 so the count never skips
  always_comb begin
    vis_c   = (h_phase == PH_ACT) && (v_phase == PH_ACT);
    line_c  = (h_cnt == HCNT_W'(H_ACTIVE)) && (v_phase == PH_ACT);
    frame_c = (h_cnt == '0) && (v_cnt == VCNT_W'(V_ACTIVE));
    first_c = (h_cnt == '0) && (v_cnt == '0);
    pixel_d = pixel_q;
    if (frame_c) begin
      pixel_d = '0;
    end else if (vis_c && !first_c) begin
      pixel_d = pixel_q + PIXEL_W'(1);
    end
  end

  // Output registers: strobes one stage behind the counters, syncs and
  // colour two stages behind the strobes so they leave the chip together
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      visible_q <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      pixel_q   <= '0;
      hs_n1_q   <= 1'b1;
      hs_n2_q   <= 1'b1;
      hsync_n_q <= 1'b1;
      vs_n1_q   <= 1'b1;
      vs_n2_q   <= 1'b1;
      vsync_n_q <= 1'b1;
      vis_dly_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      visible_q <= vis_c;
      line_q    <= line_c;
      frame_q   <= frame_c;
      pixel_q   <= pixel_d;
      hs_n1_q   <= (h_phase != PH_SYNC);
      hs_n2_q   <= hs_n1_q;
      hsync_n_q <= hs_n2_q;
      vs_n1_q   <= (v_phase != PH_SYNC);
      vs_n2_q   <= vs_n1_q;
      vsync_n_q <= vs_n2_q;
      vis_dly_q <= visible_q;
      rgb_q     <= vis_dly_q ? color_in : '0;
    end
  end

  assign visible = visible_q;
  assign line    = line_q;
  assign frame   = frame_q;
  assign pixel   = pixel_q;
  assign hsync_n = hsync_n_q;
  assign vsync_n = vsync_n_q;
  assign vga_rgb = rgb_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (8+2+3+2 x 6+2+2+3, 15x13).
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = 15;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3, VT = 13;

  logic        rst = 1'b1;
  logic        vga_clk = 1'b0;
  logic [2:0]  color_in = 3'b000;
  logic        visible, line, frame, hsync_n, vsync_n;
  logic [19:0] pixel;
  logic [2:0]  vga_rgb;

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
  ) dut (
    .rst      (rst),
    .vga_clk  (vga_clk),
    .color_in (color_in),
    .visible  (visible),
    .line     (line),
    .frame    (frame),
    .pixel    (pixel),
    .hsync_n  (hsync_n),
    .vsync_n  (vsync_n),
    .vga_rgb  (vga_rgb)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int          n;
    logic        vis, ln, fr, hs_n, vs_n;
    logic [19:0] pix;
    logic [2:0]  rgb;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   n = 0;

  // Raster position helpers (p = scan position since reset release)
  function automatic int hpos(int p); return p % HT; endfunction
  function automatic int vpos(int p); return (p / HT) % VT; endfunction
  function automatic bit vis_at(int p);
    if (p < 0) return 1'b0;
    return (hpos(p) < HA) && (vpos(p) < VA);
  endfunction
  function automatic bit hs_low_at(int p);
    if (p < 0) return 1'b0;
    return (hpos(p) >= HA + HF) && (hpos(p) < HA + HF + HS);
  endfunction
  function automatic bit vs_low_at(int p);
    if (p < 0) return 1'b0;
    return (vpos(p) >= VA + VF) && (vpos(p) < VA + VF + VS);
  endfunction

  // Expected outputs right after clock edge k since release, colour c on color_in
  function automatic exp_t model(int k, logic [2:0] c);
    exp_t e;
    int   p, h, v, pv;
    p = k - 1;
    h = hpos(p);
    v = vpos(p);
    if (v >= VA)     pv = 0;
    else if (h < HA) pv = v * HA + h;
    else             pv = v * HA + HA - 1;
    e.n    = k;
    e.vis  = vis_at(p);
    e.ln   = (h == HA) && (v < VA);
    e.fr   = (h == 0) && (v == VA);
    e.pix  = 20'(pv);
    e.hs_n = !hs_low_at(k - 3);
    e.vs_n = !vs_low_at(k - 3);
    e.rgb  = vis_at(k - 3) ? c : 3'b000;
    return e;
  endfunction

  // One stimulus cycle: drive inputs at negedge and queue the expectation
  task automatic step(input logic r, input logic [2:0] c);
    exp_t e;
    @(negedge vga_clk);
    rst      = r;
    color_in = c;
    if (r) begin
      n      = 0;
      e.n    = 0;
      e.vis  = 1'b0; e.ln = 1'b0; e.fr = 1'b0;
      e.pix  = '0;   e.hs_n = 1'b1; e.vs_n = 1'b1;
      e.rgb  = 3'b000;
    end else begin
      n = n + 1;
      e = model(n, c);
    end
    q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks = checks + 1;
    if (got != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard monitor and pulse statistics over the first frame after release
  exp_t m_e;
  int   frame_ns[$];
  int   st_lines, st_vis, st_hs, st_vs, st_rgb, st_coinc, st_adj;
  logic prev_line = 1'b0;

  always @(posedge vga_clk) begin
    #1;
    if (q.size() > 0) begin
      m_e    = q.pop_front();
      checks = checks + 1;
      if (visible !== m_e.vis || line !== m_e.ln || frame !== m_e.fr ||
          pixel !== m_e.pix || hsync_n !== m_e.hs_n || vsync_n !== m_e.vs_n ||
          vga_rgb !== m_e.rgb) begin
        errors = errors + 1;
        $display("FAIL cycle n=%0d: got vis=%b line=%b frame=%b pix=%0d hs_n=%b vs_n=%b rgb=%b expected vis=%b line=%b frame=%b pix=%0d hs_n=%b vs_n=%b rgb=%b",
                 m_e.n, visible, line, frame, pixel, hsync_n, vsync_n, vga_rgb,
                 m_e.vis, m_e.ln, m_e.fr, m_e.pix, m_e.hs_n, m_e.vs_n, m_e.rgb);
      end
      if (m_e.n == 0) begin
        frame_ns.delete();
        st_lines = 0; st_vis = 0; st_hs = 0; st_vs = 0;
        st_rgb = 0; st_coinc = 0; st_adj = 0;
      end else begin
        if (frame === 1'b1) frame_ns.push_back(m_e.n);
        if (m_e.n <= HT * VT) begin
          if (line === 1'b1)     st_lines = st_lines + 1;
          if (visible === 1'b1)  st_vis   = st_vis + 1;
          if (hsync_n === 1'b0)  st_hs    = st_hs + 1;
          if (vsync_n === 1'b0)  st_vs    = st_vs + 1;
          if (vga_rgb === 3'b101) st_rgb  = st_rgb + 1;
          if (line === 1'b1 && frame === 1'b1) st_coinc = st_coinc + 1;
        end
        if (line === 1'b1 && prev_line === 1'b1) st_adj = st_adj + 1;
      end
      prev_line = line;
    end
  end

  initial begin
    repeat (3) step(1'b1, 3'b000);

    // Frame 1: constant colour 101
    for (int i = 0; i < HT * VT; i++) step(1'b0, 3'b101);
    @(posedge vga_clk); #2;
    chk("frame1_count", frame_ns.size(), 1);
    chk("frame1_cycle", (frame_ns.size() > 0) ? frame_ns[0] : -1, 91);   // 15*6+1
    chk("lines_per_frame", st_lines, 6);
    chk("visible_per_frame", st_vis, 48);                                  // 8*6
    chk("hsync_low_cycles", st_hs, 39);                                    // 3*13
    chk("vsync_low_cycles", st_vs, 30);                                    // 2*15
    chk("rgb_101_cycles", st_rgb, 48);
    chk("line_frame_coincide", st_coinc, 0);
    chk("line_width", st_adj, 0);

    // Frame 2: colour changes every cycle so the capture cycle is pinned down
    for (int i = 0; i < HT * VT + 5; i++) step(1'b0, 3'(i * 5));
    @(posedge vga_clk); #2;
    chk("frame2_count", frame_ns.size(), 2);
    chk("frame_period", (frame_ns.size() > 1) ? frame_ns[1] - frame_ns[0] : -1, 195);

    // Run to h=5, v=3 and assert reset asynchronously mid-line
    while ((n % (HT * VT)) != 50) step(1'b0, 3'b110);
    @(posedge vga_clk); #2;
    chk("pre_reset_visible", visible, 1);
    rst = 1'b1;
    #1;
    chk("async_visible", visible, 0);
    chk("async_line", line, 0);
    chk("async_frame", frame, 0);
    chk("async_pixel", pixel, 0);
    chk("async_hsync_n", hsync_n, 1);
    chk("async_vsync_n", vsync_n, 1);
    chk("async_rgb", vga_rgb, 0);
    repeat (3) step(1'b1, 3'b110);

    for (int i = 0; i < HT * VA + 5; i++) step(1'b0, 3'(i));
    @(posedge vga_clk); #2;
    chk("post_reset_frame_count", frame_ns.size(), 1);
    chk("post_reset_frame_cycle", (frame_ns.size() > 0) ? frame_ns[0] : -1, 91);
    chk("post_reset_lines", st_lines, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
